// File: rtl/interrupt_conditioner.sv
// interrupt_conditioner: synchronises raw interrupt sources, captures level/rising-edge
// per channel into sticky pending bits, and drives masked registered outputs.
module interrupt_conditioner #(
  parameter int C_INTERRUPT_WIDTH = 1,
  parameter int C_HAS_INTERRUPT = 1,
  parameter int C_SYNC_STAGES = 2,
  parameter logic [C_INTERRUPT_WIDTH-1:0] C_EDGE_MASK = '0
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [C_INTERRUPT_WIDTH-1:0] s_interrupt,
  input  logic [C_INTERRUPT_WIDTH-1:0] irq_enable,
  input  logic [C_INTERRUPT_WIDTH-1:0] irq_clear,
  output logic [C_INTERRUPT_WIDTH-1:0] irq_pending,
  output logic [C_INTERRUPT_WIDTH-1:0] m_interrupt,
  output logic                         m_interrupt_any
);
  localparam int W = C_INTERRUPT_WIDTH;
  if (C_HAS_INTERRUPT == 0) begin : g_off
    assign irq_pending = '0;
    assign m_interrupt = '0;
    assign m_interrupt_any = 1'b0;
  end else begin : g_on
    logic [W-1:0] y, prev, pending, pending_nxt, masked;
    if (C_SYNC_STAGES == 0) begin : g_nosync
      assign y = s_interrupt;
    end else begin : g_sync
      logic [C_SYNC_STAGES-1:0][W-1:0] sync;
      always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) sync <= '0;
        else begin
          sync[0] <= s_interrupt;
          for (int k = 1; k < C_SYNC_STAGES; k++) sync[k] <= sync[k-1];
        end
      assign y = sync[C_SYNC_STAGES-1];
    end
    // a fresh rise outranks a simultaneous clear so no edge is dropped
    assign pending_nxt = (C_EDGE_MASK & ((y & ~prev) | (pending & ~irq_clear))) | (~C_EDGE_MASK & y);
    assign masked = pending & irq_enable;
    always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
        prev <= '0;
        pending <= '0;
        m_interrupt <= '0;
        m_interrupt_any <= 1'b0;
      end else begin
        prev <= y;
        pending <= pending_nxt;
        m_interrupt <= masked;
        m_interrupt_any <= |masked;
      end
    assign irq_pending = pending;
  end
endmodule

// File: tb/tb_interrupt_conditioner.sv
// tb_interrupt_conditioner: scoreboard bench over level, edge, S=0 and disabled builds.
module tb_interrupt_conditioner;
  logic aclk = 1'b0;
  logic aresetn;
  logic [3:0] s_l, en_l, clr_l, pend_l, m_l;
  logic [3:0] s_e, en_e, clr_e, pend_e, m_e;
  logic [3:0] s_0, en_0, clr_0, pend_0, m_0;
  logic [3:0] s_o, en_o, clr_o, pend_o, m_o;
  logic any_l, any_e, any_0, any_o;
  int edges = 0;
  int errors = 0;
  int checks = 0;
  typedef struct {int cyc; int id; logic [3:0] exp;} item_t;
  item_t sb[$];

  always #5 aclk = ~aclk;
  always @(posedge aclk) edges <= edges + 1;

  interrupt_conditioner #(.C_INTERRUPT_WIDTH(4), .C_SYNC_STAGES(2), .C_EDGE_MASK(4'h0)) u_lvl (
    .aclk(aclk), .aresetn(aresetn), .s_interrupt(s_l), .irq_enable(en_l), .irq_clear(clr_l),
    .irq_pending(pend_l), .m_interrupt(m_l), .m_interrupt_any(any_l));
  interrupt_conditioner #(.C_INTERRUPT_WIDTH(4), .C_SYNC_STAGES(2), .C_EDGE_MASK(4'hF)) u_edge (
    .aclk(aclk), .aresetn(aresetn), .s_interrupt(s_e), .irq_enable(en_e), .irq_clear(clr_e),
    .irq_pending(pend_e), .m_interrupt(m_e), .m_interrupt_any(any_e));
  interrupt_conditioner #(.C_INTERRUPT_WIDTH(4), .C_SYNC_STAGES(0), .C_EDGE_MASK(4'h0)) u_s0 (
    .aclk(aclk), .aresetn(aresetn), .s_interrupt(s_0), .irq_enable(en_0), .irq_clear(clr_0),
    .irq_pending(pend_0), .m_interrupt(m_0), .m_interrupt_any(any_0));
  interrupt_conditioner #(.C_INTERRUPT_WIDTH(4), .C_HAS_INTERRUPT(0), .C_EDGE_MASK(4'hF)) u_off (
    .aclk(aclk), .aresetn(aresetn), .s_interrupt(s_o), .irq_enable(en_o), .irq_clear(clr_o),
    .irq_pending(pend_o), .m_interrupt(m_o), .m_interrupt_any(any_o));

  function automatic logic [3:0] val(int id);
    case (id)
      0: val = m_l;  1: val = {3'b0, any_l};  2: val = pend_l;
      3: val = pend_e;  4: val = m_e;  5: val = {3'b0, any_e};
      6: val = m_0;  7: val = pend_0;
      8: val = m_o;  9: val = {3'b0, any_o};  10: val = pend_o;
      default: val = 4'hx;
    endcase
  endfunction

  function automatic string nm(int id);
    case (id)
      0: nm = "lvl_m";  1: nm = "lvl_any";  2: nm = "lvl_pend";
      3: nm = "edge_pend";  4: nm = "edge_m";  5: nm = "edge_any";
      6: nm = "s0_m";  7: nm = "s0_pend";
      8: nm = "off_m";  9: nm = "off_any";  10: nm = "off_pend";
      default: nm = "unknown";
    endcase
  endfunction

  // monitor: compares every scoreboard entry due at this edge
  always @(negedge aclk) begin
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].cyc <= edges) begin
        checks++;
        if (val(sb[i].id) !== sb[i].exp) begin
          errors++;
          $display("FAIL %s at edge %0d (due %0d): got %h expected %h",
                   nm(sb[i].id), edges, sb[i].cyc, val(sb[i].id), sb[i].exp);
        end
        sb.delete(i);
      end
  end

  task automatic tick(int n);
    repeat (n) @(negedge aclk);
  endtask

  // expectation j edges after the first edge that samples the current drive
  task automatic expk(int j, int id, logic [3:0] v);
    sb.push_back('{edges + 1 + j, id, v});
  endtask

  task automatic expnow(int id, logic [3:0] v);
    sb.push_back('{edges, id, v});
  endtask

  initial begin
    aresetn = 1'b0;
    {s_l, clr_l, s_e, clr_e, s_0, clr_0, s_o, en_o, clr_o} = '0;
    en_l = 4'hF; en_e = 4'hF; en_0 = 4'hF;
    tick(2);
    expk(0, 0, 4'h0); expk(0, 1, 4'h0); expk(0, 3, 4'h0); expk(0, 4, 4'h0); expk(0, 6, 4'h0);
    tick(2);
    aresetn = 1'b1;
    tick(2);
    // level pass-through, 4-edge latency both ways
    s_l = 4'h5;
    expk(1, 2, 4'h0); expk(2, 2, 4'h5); expk(2, 0, 4'h0); expk(3, 0, 4'h5); expk(3, 1, 4'h1);
    tick(6);
    s_l = 4'h0;
    expk(2, 0, 4'h5); expk(3, 0, 4'h0); expk(3, 1, 4'h0);
    tick(6);
    s_l = 4'hF; en_l = 4'h3;
    expk(3, 0, 4'h3); expk(3, 2, 4'hF);
    tick(5);
    en_l = 4'hF;
    expk(0, 0, 4'hF);
    tick(2);
    s_l = 4'h0;
    tick(5);
    // S=0 build: 2-edge latency
    s_0 = 4'h6;
    expk(0, 7, 4'h6); expk(0, 6, 4'h0); expk(1, 6, 4'h6);
    tick(3);
    s_0 = 4'h0;
    expk(0, 6, 4'h6); expk(1, 6, 4'h0);
    tick(3);
    // edge capture on bit 2 then clear
    s_e = 4'h4;
    expk(1, 3, 4'h0); expk(2, 3, 4'h4); expk(3, 4, 4'h4); expk(3, 5, 4'h1); expk(8, 3, 4'h4);
    tick(1);
    s_e = 4'h0;
    tick(10);
    clr_e = 4'h4;
    expk(0, 3, 4'h0); expk(0, 4, 4'h4); expk(1, 4, 4'h0); expk(1, 5, 4'h0);
    tick(1);
    clr_e = 4'h0;
    tick(4);
    // clear colliding with a new rise on bit 1
    s_e = 4'h2;
    expk(2, 3, 4'h2);
    tick(1);
    s_e = 4'h0;
    tick(6);
    s_e = 4'h2;
    tick(1);
    s_e = 4'h0;
    tick(1);
    clr_e = 4'h2;
    expk(0, 3, 4'h2); expk(2, 3, 4'h2);
    tick(1);
    clr_e = 4'h0;
    tick(3);
    clr_e = 4'h2;
    expk(0, 3, 4'h0);
    tick(1);
    clr_e = 4'h0;
    tick(3);
    // masking: bit 3 pends but stays silent until enabled
    en_e = 4'h7; s_e = 4'h8;
    expk(2, 3, 4'h8); expk(3, 4, 4'h0); expk(3, 5, 4'h0);
    tick(1);
    s_e = 4'h0;
    tick(6);
    en_e = 4'hF;
    expk(0, 4, 4'h8); expk(0, 5, 4'h1);
    tick(2);
    // fill pending, then reset mid-operation
    s_e = 4'h7;
    expk(2, 3, 4'hF); expk(3, 4, 4'hF);
    tick(1);
    s_e = 4'h0;
    tick(5);
    @(posedge aclk); #2;
    aresetn = 1'b0;
    expnow(3, 4'h0); expnow(4, 4'h0); expnow(5, 4'h0);
    tick(3);
    aresetn = 1'b1;
    expk(0, 3, 4'h0); expk(4, 3, 4'h0); expk(4, 4, 4'h0); expk(4, 5, 4'h0);
    tick(6);
    // reset with edge inputs held high: one rise per channel after release
    @(posedge aclk); #2;
    aresetn = 1'b0; s_e = 4'hF;
    expnow(3, 4'h0); expnow(4, 4'h0);
    tick(3);
    aresetn = 1'b1;
    expk(1, 3, 4'h0); expk(2, 3, 4'hF); expk(3, 4, 4'hF); expk(3, 5, 4'h1);
    tick(6);
    s_e = 4'h0;
    // disabled build under random stimulus
    repeat (12) begin
      s_o = 4'($urandom); en_o = 4'($urandom); clr_o = 4'($urandom);
      expk(0, 8, 4'h0); expk(0, 9, 4'h0); expk(0, 10, 4'h0);
      tick(1);
    end
    for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
